// File: rtl/pipeline_stage_skid_if.sv
// rtl/pipeline_stage_skid_if.sv - upstream/downstream handshake bundle for pipeline_stage_skid
interface pipeline_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rd;

  modport master (
    output in_valid, in_data, in_ctrl, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_rd
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_rd
  );
endinterface

// File: rtl/pipeline_stage_skid.sv
// rtl/pipeline_stage_skid.sv - two-entry (main + skid) pipeline register with flush and bubble counter
module pipeline_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic [CNT_W-1:0]      bubble_cnt,
  pipeline_stage_skid_if.slave  bus
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [4:0]        main_rd;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [4:0]        skid_rd;
  logic              accept;
  logic              drain;

  // in_ready comes straight from the skid flop, so it never sees out_ready.
  assign bus.in_ready = ~skid_valid;
  assign accept       = bus.in_valid & ~skid_valid;
  assign drain        = main_valid & bus.out_ready;

  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_valid ? main_data : '0;
  assign bus.out_ctrl  = main_valid ? main_ctrl : NOP_CTRL;
  assign bus.out_rd    = main_valid ? main_rd   : 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      main_rd    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_rd    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      // A full skid implies in_ready was low, so no input competes with it.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        main_rd    <= skid_rd;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= bus.in_data;
        main_ctrl  <= bus.in_ctrl;
        main_rd    <= bus.in_rd;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= bus.in_data;
      skid_ctrl  <= bus.in_ctrl;
      skid_rd    <= bus.in_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bus.out_ready && !main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb/tb_pipeline_stage_skid.sv - directed and scoreboard checks for pipeline_stage_skid
module tb_pipeline_stage_skid;
  localparam logic [3:0] NOP = 4'hA;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic [4:0]  r;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;
  logic        flush2 = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  pipeline_stage_skid_if #(.DATA_W(32), .CTRL_W(4)) bus ();
  pipeline_stage_skid_if #(.DATA_W(32), .CTRL_W(4)) bus2 ();

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(4), .NOP_CTRL(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bubble_cnt(bubble_cnt), .bus(bus)
  );

  pipeline_stage_skid #(.DATA_W(32), .CTRL_W(4), .NOP_CTRL(4'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .bubble_cnt(bubble_cnt2), .bus(bus2)
  );

  assign bus2.in_valid  = 1'b0;
  assign bus2.in_data   = '0;
  assign bus2.in_ctrl   = '0;
  assign bus2.in_rd     = '0;
  assign bus2.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c, input logic [4:0] r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    bus.in_rd    = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    bus.out_ready = 1'b0;
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_ctrl !== NOP) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want %h", bus.out_ctrl, NOP); end
    n_cmp++; if (bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd: got %0d want 0", bus.out_rd); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
  endtask

  task automatic test_bubbles();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        n_cmp++; if (bubble_cnt2 !== 2'd2) begin n_fail++; $display("FAIL bubble_w2_at2: got %0d want 2", bubble_cnt2); end
      end
      if (i == 5) begin
        n_cmp++; if (bubble_cnt !== 16'd5) begin n_fail++; $display("FAIL bubble_at5: got %0d want 5", bubble_cnt); end
      end
    end
    n_cmp++; if (bubble_cnt !== 16'd10) begin n_fail++; $display("FAIL bubble_at10: got %0d want 10", bubble_cnt); end
    n_cmp++; if (bubble_cnt2 !== 2'd3) begin n_fail++; $display("FAIL bubble_w2_sat: got %0d want 3", bubble_cnt2); end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 1), 4'(i + 1), 5'(i + 5));
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i + 1) || bus.out_ctrl !== 4'(i + 1) || bus.out_rd !== 5'(i + 5))
        begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h r=%0d want v=1 d=%h c=%h r=%0d", i, bus.out_valid, bus.out_data, bus.out_ctrl, bus.out_rd, i + 1, i + 1, i + 5); end
    end
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 32'h10, 4'h1, 5'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h20, 4'h2, 5'd2);
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 32'h10) begin n_fail++; $display("FAIL bp_hold_a: got %h want 10", bus.out_data); end
    drive(1'b1, 32'h30, 4'h3, 5'd3);
    @(posedge clk); #1;
    n_cmp++; if (bus.out_data !== 32'h10 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got d=%h rdy=%b want d=10 rdy=0", bus.out_data, bus.in_ready); end
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_data !== 32'h20 || bus.out_rd !== 5'd2) begin n_fail++; $display("FAIL bp_second_b: got d=%h r=%0d want d=20 r=2", bus.out_data, bus.out_rd); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h11, 4'h1, 5'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h22, 4'h2, 5'd2);
    @(posedge clk); #1;
    flush = 1'b1;
    drive(1'b1, 32'h33, 4'h5, 5'd7);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== NOP || bus.out_rd !== 5'd0 || bus.out_data !== 32'h0)
      begin n_fail++; $display("FAIL flush_full: got v=%b c=%h r=%0d d=%h want v=0 c=%h r=0 d=0", bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_data, NOP); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got v=1 d=%h want v=0", i, bus.out_data); end
    end
    flush = 1'b1;
    drive(1'b1, 32'h44, 4'h4, 5'd4);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_beats_accept: got v=1 d=%h want v=0", bus.out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h55, 4'h1, 5'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h66, 4'h2, 5'd2);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0)
      begin n_fail++; $display("FAIL async_reset: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", bus.out_valid, bus.in_ready, bus.out_data); end
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h77, 4'h7, 5'd9);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin n_fail++; $display("FAIL first_accept_after_rst: got v=%b d=%h want v=1 d=77", bus.out_valid, bus.out_data); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_entries_discarded: got v=1 d=%h want v=0", bus.out_data); end
  endtask

  task automatic test_random();
    item_t q[$];
    item_t it;
    item_t got;
    item_t want;
    int    delivered = 0;
    logic  acc;
    logic  drn;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      it.d = $urandom;
      it.c = 4'($urandom);
      it.r = 5'($urandom);
      drive(1'($urandom_range(0, 2) != 0), it.d, it.c, it.r);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      #3;
      n_cmp++; if (bus.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b want %b", cyc, bus.out_valid, q.size() > 0); end
      n_cmp++; if (bus.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b want %b", cyc, bus.in_ready, q.size() < 2); end
      got  = {bus.out_data, bus.out_ctrl, bus.out_rd};
      want = (q.size() > 0) ? q[0] : {32'h0, NOP, 5'd0};
      n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rand_payload@%0d: got %h want %h", cyc, got, want); end
      acc = bus.in_valid && (q.size() < 2);
      drn = bus.out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (drn) begin void'(q.pop_front()); delivered++; end
        if (acc) q.push_back(it);
      end
      #1;
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    n_cmp++; if (delivered < 1000) begin n_fail++; $display("FAIL rand_throughput: got %0d delivered want >= 1000", delivered); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 5'd0);
    test_reset();
    test_bubbles();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_skid.md
PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the data payload (ALU result, store data, PC+4 packed by the caller).
REQ-002 Parameter CTRL_W, default 4, SHALL set the width of the control payload (RegWrite, ResultSrc, memory write, WD3Src, ...).
REQ-003 Parameter NOP_CTRL, default all-zero CTRL_W bits, SHALL be the control word driven whenever no valid instruction is presented.
REQ-004 Parameter CNT_W, default 16, SHALL set the bubble counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  upstream stage holds a valid instruction.
REQ-008 in_ready  out  1  this stage can accept an instruction this cycle.
REQ-009 in_data  in  DATA_W  upstream data payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 in_rd  in  5  destination register index.
REQ-012 flush  in  1  synchronous kill of all held and incoming instructions.
REQ-013 out_valid  out  1  downstream stage is presented a valid instruction.
REQ-014 out_ready  in  1  downstream accepts the presented instruction.
REQ-015 out_data  out  DATA_W, out_ctrl  out  CTRL_W, out_rd  out  5  presented payload.
REQ-016 bubble_cnt  out  CNT_W  count of cycles downstream was ready but nothing valid was presented.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; each with its own valid bit.
REQ-018 in_ready SHALL be registered and equal NOT skid_valid; it SHALL NOT depend combinationally on out_ready.
REQ-019 Accept SHALL occur when in_valid && in_ready; drain SHALL occur when out_valid && out_ready.
REQ-020 Main SHALL load when main is empty or drained: from skid if skid_valid, else from input if accepted, else main becomes empty.
REQ-021 An accepted input SHALL go to skid when main is valid, not drained, and skid is empty; skid is freed when it moves into main.
REQ-022 Simultaneous drain and accept with skid empty SHALL load input directly into main (no bubble, full throughput).
REQ-023 Latency SHALL be exactly 1 cycle from accept to out_valid when the stage is empty.
REQ-024 Ordering SHALL be preserved; no instruction is duplicated or dropped except by flush.
REQ-025 When out_valid=0: out_ctrl SHALL equal NOP_CTRL, out_rd SHALL be 0, out_data SHALL be 0.
REQ-026 flush SHALL clear main_valid and skid_valid at the next edge and discard any input accepted in that cycle; flush takes priority over accept and drain.
REQ-027 in_ready SHALL be 1 in the cycle after flush.
REQ-028 bubble_cnt SHALL increment by 1 each cycle with out_ready=1 and out_valid=0, saturating at all-ones; flush cycles count if the condition holds.

Reset
REQ-029 rst high SHALL immediately clear main_valid, skid_valid, bubble_cnt; outputs become out_valid=0, out_ctrl=NOP_CTRL, out_rd=0, out_data=0, in_ready=1.
REQ-030 Assertion of rst mid-transfer SHALL discard both entries; first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-031 Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 on cycles 1-4, in_ready constant 1.
REQ-032 Backpressure: send A=0x10, B=0x20, out_ready=0 -> after two cycles in_ready=0, out_data=0x10; raise out_ready -> 0x10 then 0x20, in_ready returns 1.
REQ-033 Flush: main and skid full, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=NOP_CTRL, out_rd=0, C never appears.
REQ-034 Bubbles: in_valid=0, out_ready=1 for 5 cycles from reset -> bubble_cnt=5; with CNT_W=2, 10 cycles -> bubble_cnt=3.
REQ-035 Async reset: assert rst between edges with entries held -> out_valid=0 and in_ready=1 before the next edge.
REQ-036 Random: random in_valid/out_ready/flush for 10k cycles -> scoreboard shows in-order delivery, no loss except flush-killed entries.
